mul_share_sched: RTL and testbench

Round-robin scheduler and sequencer that shares one repeated-addition multiply datapath among `NREQ` requesters. It arbitrates between requests and drives the datapath's load, clear, accumulate and decrement controls. It watches the datapath's zero flag and returns the product to the granted requester with a one-cycle `done` pulse. It sits between the requesting blocks and a single multiplier datapath with A, B and P registers.

---
 rtl/mul_share_sched.sv | 88 ++++++++
 tb/tb_mul_share_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/mul_share_sched.sv
// mul_share_sched: round-robin sequencer sharing one repeated-addition multiplier among NREQ requesters.
module mul_share_sched #(
  parameter int W    = 16,
  parameter int NREQ = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [NREQ-1:0]   gnt,
  output logic [NREQ-1:0]   done,
  output logic [W-1:0]      result,
  output logic              busy,
  output logic [W-1:0]      dp_data,
  output logic              ld_a,
  output logic              ld_b,
  output logic              clr_p,
  output logic              ld_p,
  output logic              dec_b,
  input  logic              eqz,
  input  logic [W-1:0]      dp_prod
);
  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  typedef enum logic [2:0] {IDLE, LOAD_A, LOAD_B, MUL, DONE} state_t;
  state_t state, state_nx;
  logic [IW-1:0] ptr, gid, sel, idx;
  logic found;
  // Scan downward so the index closest to ptr (wrapping) is the last one kept.
  always_comb begin
    sel = ptr;
    idx = '0;
    found = 1'b0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = IW'((int'(ptr) + k) % NREQ);
      if (req[idx]) begin
        sel = idx;
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      ptr    <= '0;
      gid    <= '0;
      result <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && found) gid <= sel;
      if (state == MUL && eqz) result <= dp_prod;
      if (state == DONE) ptr <= (gid == IW'(NREQ - 1)) ? '0 : gid + 1'b1;
    end
  end
  always_comb begin
    state_nx = state;
    busy     = state != IDLE;
    gnt      = busy ? NREQ'(1) << gid : '0;
    done     = (state == DONE) ? gnt : '0;
    dp_data  = '0;
    ld_a     = 1'b0;
    ld_b     = 1'b0;
    clr_p    = 1'b0;
    ld_p     = 1'b0;
    dec_b    = 1'b0;
    case (state)
      IDLE:   state_nx = found ? LOAD_A : IDLE;
      LOAD_A: begin
        dp_data  = req_a[int'(gid)*W +: W];
        ld_a     = 1'b1;
        state_nx = LOAD_B;
      end
      LOAD_B: begin
        dp_data  = req_b[int'(gid)*W +: W];
        ld_b     = 1'b1;
        clr_p    = 1'b1;
        state_nx = MUL;
      end
      MUL: begin
        ld_p     = !eqz;
        dec_b    = !eqz;
        state_nx = eqz ? DONE : MUL;
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end
endmodule

// File: tb/tb_mul_share_sched.sv
// tb_mul_share_sched: vector table, corner sequences and random traffic against a round-robin/arithmetic model.
module tb_mul_share_sched;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] req_a, req_b;
  logic [3:0]  gnt, done;
  logic [15:0] result, dp_data, dp_prod;
  logic        busy, ld_a, ld_b, clr_p, ld_p, dec_b, eqz;
  logic [15:0] ra, rb, rp;
  int checks = 0, errors = 0, mptr = 0;

  mul_share_sched #(.W(16), .NREQ(4)) dut (
    .clk(clk), .rst(rst), .req(req), .req_a(req_a), .req_b(req_b),
    .gnt(gnt), .done(done), .result(result), .busy(busy), .dp_data(dp_data),
    .ld_a(ld_a), .ld_b(ld_b), .clr_p(clr_p), .ld_p(ld_p), .dec_b(dec_b),
    .eqz(eqz), .dp_prod(dp_prod)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ld_a) ra <= dp_data;
    if (ld_b) rb <= dp_data;
    else if (dec_b) rb <= rb - 16'd1;
    if (clr_p) rp <= '0;
    else if (ld_p) rp <= rp + ra;
  end
  assign eqz     = rb == 16'd0;
  assign dp_prod = rp;

  typedef struct {
    int          idx;
    logic [15:0] a;
    logic [15:0] b;
    logic [15:0] exp;
  } vec_t;
  vec_t tv[5];

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_op(input int i, input logic [15:0] a, input logic [15:0] b);
    req_a[i*16 +: 16] = a;
    req_b[i*16 +: 16] = b;
  endtask

  function automatic longint outs();
    return {gnt, done, result, busy, dp_data, ld_a, ld_b, clr_p, ld_p, dec_b};
  endfunction

  // Expected winner: first pending index at or after the model pointer, with wrap.
  task automatic serve(input logic drop, output int id, output logic [15:0] res);
    int t, nldp, gbad, eid;
    logic [3:0] g;
    logic [15:0] ea, eb;
    logic [31:0] p;
    eid = 0;
    for (int k = 3; k >= 0; k--) if (req[(mptr + k) % 4]) eid = (mptr + k) % 4;
    ea = req_a[eid*16 +: 16];
    eb = req_b[eid*16 +: 16];
    p  = ea * eb;
    t  = 0;
    do begin
      @(negedge clk);
      t++;
    end while (gnt == 4'd0 && t < 30);
    chk("grant", gnt, 64'(1) << eid);
    g = gnt;
    t = 1;
    nldp = int'(ld_p);
    gbad = 0;
    while (done == 4'd0 && t < int'(eb) + 20) begin
      @(negedge clk);
      t++;
      nldp += int'(ld_p);
      if (gnt != g) gbad++;
    end
    chk("done_id", done, g);
    chk("latency", t - 1, int'(eb) + 3);
    chk("ldp_count", nldp, eb);
    chk("product", result, p[15:0]);
    chk("gnt_stable", gbad, 0);
    id   = eid;
    res  = result;
    mptr = (eid + 1) % 4;
    if (drop) req[eid] = 1'b0;
  endtask

  initial begin
    int id, dsum;
    logic [15:0] res;
    int order[5]  = '{0, 1, 2, 3, 0};
    int fres[5]   = '{2, 4, 6, 8, 2};
    tv[0] = '{0, 16'd17, 16'd5, 16'd85};
    tv[1] = '{0, 16'd17, 16'd0, 16'd0};
    tv[2] = '{1, 16'd300, 16'd300, 16'd24464};
    tv[3] = '{3, 16'd65535, 16'd2, 16'd65534};
    tv[4] = '{2, 16'd1, 16'd1, 16'd1};
    rst = 1'b1; req = '0; req_a = '0; req_b = '0;
    repeat (2) @(negedge clk);
    chk("reset_outputs", outs(), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    chk("idle_busy", busy, 0);

    for (int v = 0; v < 5; v++) begin
      set_op(tv[v].idx, tv[v].a, tv[v].b);
      req[tv[v].idx] = 1'b1;
      serve(1'b1, id, res);
      chk("vec_id", id, tv[v].idx);
      chk("vec_result", res, tv[v].exp);
    end

    // Fairness with every request held continuously.
    @(negedge clk);
    repeat (3) @(negedge clk);
    rst = 1'b1; mptr = 0;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) set_op(i, 16'(i + 1), 16'd2);
    req = 4'hF;
    for (int n = 0; n < 5; n++) begin
      serve(1'b0, id, res);
      chk("fair_order", id, order[n]);
      chk("fair_result", res, fres[n]);
    end
    req = '0;

    // Pointer rotation: after requester 2, 3 outranks 0.
    set_op(2, 16'd3, 16'd1);
    req = 4'b0100;
    serve(1'b1, id, res);
    chk("rot_first", id, 2);
    set_op(0, 16'd5, 16'd3);
    set_op(3, 16'd7, 16'd2);
    req = 4'b1001;
    serve(1'b1, id, res);
    chk("rot_second", id, 3);
    serve(1'b1, id, res);
    chk("rot_third", id, 0);
    chk("rot_third_res", res, 15);

    // Reset in the fourth MUL cycle aborts and resets the pointer.
    @(negedge clk);
    set_op(0, 16'd9, 16'd10);
    req = 4'b0001;
    for (int t = 0; t < 30 && gnt == 4'd0; t++) @(negedge clk);
    repeat (5) @(negedge clk);
    chk("pre_reset_dec", dec_b, 1);
    #2 rst = 1'b1;
    #1 chk("abort_outputs", outs(), 0);
    req = '0;
    dsum = 0;
    repeat (3) begin
      @(negedge clk);
      dsum += int'(done != 4'd0);
    end
    chk("abort_no_done", dsum, 0);
    rst = 1'b0;
    mptr = 0;
    set_op(0, 16'd6, 16'd7);
    set_op(2, 16'd4, 16'd4);
    req = 4'b0101;
    serve(1'b1, id, res);
    chk("post_reset_id", id, 0);
    chk("post_reset_res", res, 42);
    serve(1'b1, id, res);
    chk("post_reset_id2", id, 2);

    for (int it = 0; it < 16; it++) begin
      for (int i = 0; i < 4; i++) set_op(i, 16'($urandom), 16'($urandom_range(0, 12)));
      req = 4'($urandom_range(1, 15));
      while (req != 4'd0) serve(1'b1, id, res);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
